// File: rtl/key_pkg.sv
// key_pkg: shared repeat-state encoding and counter width helper for the key debouncer
package key_pkg;
    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2,
        R_HELD   = 2'd3
    } rstate_t;
    function automatic int clog2w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: synchroniser, debounce counter and auto-repeat FSM for one key
module key_debounce_chan
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    localparam int CW = clog2w(DEBOUNCE_CYCLES);
    localparam int TW = clog2w(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE);
    logic [1:0]    r_sync;
    logic          r_state;
    logic [CW-1:0] r_cnt;
    rstate_t       r_rs, w_rs_n;
    logic [TW-1:0] r_tmr, w_tmr_n;
    logic          r_press, r_release, r_repeat;
    logic          w_pressed, w_diff, w_toggle, w_press, w_release, w_pulse;
    assign w_pressed = ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
    assign w_diff    = w_pressed != r_state;
    assign w_toggle  = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_press   = w_toggle & ~r_state;
    assign w_release = w_toggle & r_state;
    always_comb begin
        w_rs_n  = r_rs;
        w_tmr_n = r_tmr + 1'b1;
        w_pulse = 1'b0;
        if (w_release) begin
            w_rs_n  = R_IDLE;
            w_tmr_n = '0;
        end else begin
            case (r_rs)
                R_IDLE: begin
                    w_tmr_n = '0;
                    if (w_press) begin
                        w_pulse = 1'b1;
                        w_rs_n  = i_repeat_en ? R_DELAY : R_HELD;
                    end
                end
                R_DELAY: begin
                    if (!i_repeat_en) begin
                        w_rs_n  = R_HELD;
                        w_tmr_n = '0;
                    end else if (r_tmr == TW'(REPEAT_DELAY - 1)) begin
                        w_pulse = 1'b1;
                        w_tmr_n = '0;
                        w_rs_n  = R_REPEAT;
                    end
                end
                R_REPEAT: begin
                    if (!i_repeat_en) begin
                        w_rs_n  = R_HELD;
                        w_tmr_n = '0;
                    end else if (r_tmr == TW'(REPEAT_RATE - 1)) begin
                        w_pulse = 1'b1;
                        w_tmr_n = '0;
                    end
                end
                default: begin
                    w_tmr_n = '0;
                    w_rs_n  = i_repeat_en ? R_DELAY : R_HELD;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= {2{ACTIVE_LOW}};
            r_state   <= 1'b0;
            r_cnt     <= '0;
            r_rs      <= R_IDLE;
            r_tmr     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key};
            r_cnt     <= (w_diff && !w_toggle) ? r_cnt + 1'b1 : '0;
            r_state   <= r_state ^ w_toggle;
            r_rs      <= w_rs_n;
            r_tmr     <= w_tmr_n;
            r_press   <= w_press;
            r_release <= w_release;
            r_repeat  <= w_pulse;
        end
    end
    assign o_level   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;
endmodule

// File: rtl/key_repeat_debouncer.sv
// key_repeat_debouncer: N independent debounced keys with press/release/auto-repeat pulses
module key_repeat_debouncer
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 15000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 || N_KEYS < 1) begin : g_bad_params
        $fatal(1, "key_repeat_debouncer: parameter below legal minimum");
    end
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_chan #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_key      (keys_in[i]),
            .i_repeat_en(repeat_en[i]),
            .o_level    (key_level[i]),
            .o_press    (key_press[i]),
            .o_release  (key_release[i]),
            .o_repeat   (key_repeat[i])
        );
    end
endmodule

// File: tb/tb_key_repeat_debouncer.sv
// tb_key_repeat_debouncer: directed edge-by-edge checks of debounce, pulses and auto-repeat
module tb_key_repeat_debouncer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] keys_in, repeat_en;
    logic [1:0] key_level, key_press, key_release, key_repeat;
    int         checks = 0;
    int         errors = 0;

    key_repeat_debouncer #(
        .N_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst(rst), .keys_in(keys_in), .repeat_en(repeat_en),
        .key_level(key_level), .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic on_rep(input int e, input int first, input int last);
        return e >= first && e <= last && (e - first) % 3 == 0;
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1; keys_in = 2'b11; repeat_en = 2'b11;
        #3;
        obs = {key_level, key_press, key_release, key_repeat};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_hold got %b exp %b", obs, 8'h00); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== 8'h00) begin errors++; $display("FAIL reset_idle edge %0d got %b exp %b", e, obs, 8'h00); end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] obs;
        keys_in[0] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            keys_in[0] = 1'b1;
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== 8'h00) begin errors++; $display("FAIL glitch1 edge %0d got %b exp %b", e, obs, 8'h00); end
        end
        for (int e = 1; e <= 12; e++) begin
            keys_in[0] = (e <= 3) ? 1'b0 : 1'b1;
            tick();
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== 8'h00) begin errors++; $display("FAIL glitch3 edge %0d got %b exp %b", e, obs, 8'h00); end
        end
    endtask

    task automatic test_press_release();
        logic [7:0] obs, exp;
        keys_in[0] = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (e == 31) keys_in[0] = 1'b1;
            tick();
            exp = {1'b0, e >= 6 && e < 36, 1'b0, e == 6, 1'b0, e == 36, 1'b0, e == 6 || on_rep(e, 16, 34)};
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL press_release edge %0d got %b exp %b", e, obs, exp); end
        end
    endtask

    task automatic test_repeat_disabled();
        logic [7:0] obs, exp;
        repeat_en[1] = 1'b0;
        keys_in[1] = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            if (e == 41) keys_in[1] = 1'b1;
            tick();
            exp = {e >= 6 && e < 46, 1'b0, e == 6, 1'b0, e == 46, 1'b0, e == 6, 1'b0};
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL repeat_disabled edge %0d got %b exp %b", e, obs, exp); end
        end
        repeat_en[1] = 1'b1;
    endtask

    task automatic test_enable_toggle();
        logic [7:0] obs, exp;
        logic       rp;
        keys_in[0] = 1'b0;
        for (int e = 1; e <= 55; e++) begin
            if (e == 23) repeat_en[0] = 1'b0;
            if (e == 28) repeat_en[0] = 1'b1;
            if (e == 46) keys_in[0] = 1'b1;
            tick();
            rp = e == 6 || on_rep(e, 16, 22) || on_rep(e, 38, 50);
            exp = {1'b0, e >= 6 && e < 51, 1'b0, e == 6, 1'b0, e == 51, 1'b0, rp};
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL enable_toggle edge %0d got %b exp %b", e, obs, exp); end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] obs, exp;
        keys_in[0] = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        checks++;
        if (key_level !== 2'b01) begin errors++; $display("FAIL hold_before_reset got %b exp %b", key_level, 2'b01); end
        rst = 1'b1;
        #1;
        obs = {key_level, key_press, key_release, key_repeat};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL async_reset got %b exp %b", obs, 8'h00); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 13) keys_in[0] = 1'b1;
            tick();
            exp = {1'b0, e >= 6 && e < 18, 1'b0, e == 6, 1'b0, e == 18, 1'b0, e == 6 || e == 16};
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_hold edge %0d got %b exp %b", e, obs, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] obs, exp;
        logic [1:0] lv, pr, rl, rp;
        keys_in = 2'b00;
        for (int e = 1; e <= 38; e++) begin
            if (e == 20) keys_in[0] = 1'b1;
            if (e == 29) keys_in[1] = 1'b1;
            tick();
            lv = {e >= 6 && e < 34, e >= 6 && e < 25};
            pr = {e == 6, e == 6};
            rl = {e == 34, e == 25};
            rp = {e == 6 || on_rep(e, 16, 31), e == 6 || on_rep(e, 16, 22)};
            exp = {lv, pr, rl, rp};
            obs = {key_level, key_press, key_release, key_repeat};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL back_to_back edge %0d got %b exp %b", e, obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_release();
        test_repeat_disabled();
        test_enable_toggle();
        test_reset_mid_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
